// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the datapath and a word-wide data memory.
// It takes one request at a time. Sub-word stores are done as read-modify-write.
// Byte order is big-endian: byte offset 0 is bits [31:24].
//
// Handshake: the request fields are sampled on the clock edge where start=1 and the
// unit is idle (busy=0). A start seen while busy is dropped and never queued. Each
// accepted request produces exactly one done pulse, one cycle long, and err is valid
// in that cycle. A reset that arrives mid-request aborts it with no done pulse.
module mem_access_unit #(
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       st_data,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [MEM_AW-1:0] m_addr,
  output logic [31:0]       m_wd,
  output logic              m_we,
  input  logic [31:0]       m_rd,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      r_state;
  logic        r_is_store;
  logic [1:0]  r_size;
  logic        r_sign_ext;
  logic [31:0] r_addr;
  logic [31:0] r_st_data;
  logic [31:0] r_old_word;
  logic [31:0] r_ld_data;
  logic        r_err;

  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_ext;
  logic [31:0] w_wd;

  // Classify the incoming request; only meaningful while idle with start high.
  always_comb begin
    w_misaligned = 1'b0;
    if (size == SZ_ILL) begin
      w_misaligned = 1'b1;
    end else if ((size == SZ_HALF) && addr[0]) begin
      w_misaligned = 1'b1;
    end else if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) begin
      w_misaligned = 1'b1;
    end
  end

  // Pick the addressed byte/half out of the read word and extend it to 32 bits.
  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    w_ld_ext = m_rd;
    case (r_addr[1:0])
      2'd0:    w_byte = m_rd[31:24];
      2'd1:    w_byte = m_rd[23:16];
      2'd2:    w_byte = m_rd[15:8];
      default: w_byte = m_rd[7:0];
    endcase
    w_half = r_addr[1] ? m_rd[15:0] : m_rd[31:16];
    case (r_size)
      SZ_BYTE: w_ld_ext = {{24{r_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: w_ld_ext = {{16{r_sign_ext & w_half[15]}}, w_half};
      default: w_ld_ext = m_rd;
    endcase
  end

  // Build the write word: a full-word store passes st_data through; sub-word
  // stores splice the new lane into the word read in the RD state.
  always_comb begin
    w_wd = r_st_data;
    if (r_size == SZ_BYTE) begin
      w_wd = r_old_word;
      case (r_addr[1:0])
        2'd0:    w_wd[31:24] = r_st_data[7:0];
        2'd1:    w_wd[23:16] = r_st_data[7:0];
        2'd2:    w_wd[15:8]  = r_st_data[7:0];
        default: w_wd[7:0]   = r_st_data[7:0];
      endcase
    end else if (r_size == SZ_HALF) begin
      w_wd = r_old_word;
      if (r_addr[1]) begin
        w_wd[15:0] = r_st_data[15:0];
      end else begin
        w_wd[31:16] = r_st_data[15:0];
      end
    end
  end

  // Request FSM: latch on accept, read, optional write, then one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_size     <= 2'b00;
      r_sign_ext <= 1'b0;
      r_addr     <= 32'h0;
      r_st_data  <= 32'h0;
      r_old_word <= 32'h0;
      r_ld_data  <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store <= is_store;
            r_size     <= size;
            r_sign_ext <= sign_ext;
            r_addr     <= addr;
            r_st_data  <= st_data;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err <= 1'b0;
              if (is_store && (size == SZ_WORD)) begin
                r_state <= S_WR;
              end else begin
                r_state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (r_is_store) begin
            r_old_word <= m_rd;
            r_state    <= S_WR;
          end else begin
            r_ld_data <= w_ld_ext;
            r_state   <= S_DONE;
          end
        end
        S_WR: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and memory-port outputs are decoded from the registered state.
  // m_we is gated by rst so that a reset in the WR cycle blocks the write.
  always_comb begin
    done      = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    m_we      = (r_state == S_WR) & ~rst;
    err       = r_err;
    ld_data   = r_ld_data;
    m_addr    = MEM_AW'(r_addr >> 2);
    m_wd      = w_wd;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed bench for mem_access_unit, checked
// against a byte-level memory/load model kept in the bench.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        done;
  logic        busy;
  logic        err;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic        m_we;
  logic [31:0] m_rd;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem     [0:15];
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_q[$];

  mem_access_unit #(.MEM_AW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .st_data(st_data), .ld_data(ld_data),
    .done(done), .busy(busy), .err(err), .m_addr(m_addr), .m_wd(m_wd),
    .m_we(m_we), .m_rd(m_rd), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: asynchronous read, write on posedge
  assign m_rd = mem[m_addr[3:0]];
  always @(posedge clk) begin
    if (m_we === 1'b1) mem[m_addr[3:0]] <= m_wd;
  end

  task automatic init_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[1] = 32'h12345678; ref_mem[1] = 32'h12345678;
    mem[2] = 32'h80FF0000; ref_mem[2] = 32'h80FF0000;
  endtask

  // driver: present one request, wait for done (bounded), then let the unit
  // return to idle. lat = edges from accept to done-visible, 0 on timeout.
  task automatic drive_req(input logic st, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic e, output int we_n,
                           output logic [31:0] rd_addr);
    lat = 0; e = 1'b0; we_n = 0; rd_addr = 32'hx;
    @(negedge clk);
    is_store = st; size = sz; sign_ext = sx; addr = a; st_data = d; start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0;
        rd_addr = m_addr;
      end
      if (m_we === 1'b1) we_n++;
      if (done === 1'b1) begin
        lat = n;
        e = err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // reference: big-endian lane extraction by shifting
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sx, input logic [1:0] k);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * (3 - k))) & 32'hFF;
      if (sx && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * (1 - k[1]))) & 32'hFFFF;
      if (sx && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] k, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * (3 - k);
      mask = 32'hFF << sh;
      return (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * (1 - k[1]);
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; st_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    n_checks++;
    if (m_we !== 1'b0) $display("FAIL reset_m_we got=%b exp=0", m_we); else n_pass++;
    n_checks++;
    if (ld_data !== 32'h0) $display("FAIL reset_ld_data got=%h exp=00000000", ld_data); else n_pass++;
    n_checks++;
    if ($isunknown({m_addr, m_wd})) $display("FAIL reset_port_x got=%h/%h exp=known", m_addr, m_wd);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lw();
    int lat; logic e; int we_n; logic [31:0] ra;
    drive_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, lat, e, we_n, ra);
    n_checks++;
    if (ra !== 32'd1) $display("FAIL lw_m_addr got=%h exp=1", ra); else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL lw_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++;
    if (ld_data !== 32'h12345678) $display("FAIL lw_data got=%h exp=12345678", ld_data); else n_pass++;
    n_checks++;
    if (we_n !== 0 || e !== 1'b0) $display("FAIL lw_we_err got=%0d/%b exp=0/0", we_n, e); else n_pass++;
  endtask

  task automatic test_subword_loads();
    logic [1:0]  t_sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        t_sx [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_a  [4] = '{32'd5, 32'd8, 32'd8, 32'd10};
    logic [31:0] t_e  [4] = '{32'h00000034, 32'hFFFFFF80, 32'hFFFF80FF, 32'h00000000};
    int lat; logic e; int we_n; logic [31:0] ra;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, t_sz[i], t_sx[i], t_a[i], 32'h0, lat, e, we_n, ra);
      n_checks++;
      if (ld_data !== t_e[i] || lat !== 2 || e !== 1'b0)
        $display("FAIL subload_%0d got=%h lat=%0d err=%b exp=%h lat=2 err=0", i, ld_data, lat, e, t_e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_subword_stores();
    int lat; logic e; int we_n; logic [31:0] ra;
    drive_req(1'b1, 2'b00, 1'b0, 32'd6, 32'h000000AB, lat, e, we_n, ra);
    n_checks++;
    if (lat !== 3 || we_n !== 1) $display("FAIL sb_timing got=lat%0d/we%0d exp=lat3/we1", lat, we_n);
    else n_pass++;
    n_checks++;
    if (mem[1] !== 32'h1234AB78) $display("FAIL sb_mem got=%h exp=1234AB78", mem[1]); else n_pass++;
    drive_req(1'b1, 2'b01, 1'b0, 32'd4, 32'h0000BEEF, lat, e, we_n, ra);
    n_checks++;
    if (mem[1] !== 32'hBEEFAB78 || lat !== 3 || we_n !== 1)
      $display("FAIL sh_mem got=%h lat=%0d we=%0d exp=BEEFAB78 lat=3 we=1", mem[1], lat, we_n);
    else n_pass++;
    n_checks++;
    if (ld_data !== 32'h00000000) $display("FAIL store_keeps_ld got=%h exp=00000000", ld_data); else n_pass++;
    ref_mem[1] = 32'hBEEFAB78;
  endtask

  task automatic test_errors();
    logic        t_st [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] t_a  [3] = '{32'd6, 32'd5, 32'd4};
    int lat; logic e; int we_n; logic [31:0] ra;
    logic [31:0] ld_before, m1, m2;
    for (int i = 0; i < 3; i++) begin
      ld_before = ld_data; m1 = mem[1]; m2 = mem[2];
      drive_req(t_st[i], t_sz[i], 1'b0, t_a[i], 32'hCAFE_F00D, lat, e, we_n, ra);
      n_checks++;
      if (lat !== 1 || e !== 1'b1 || we_n !== 0)
        $display("FAIL err_%0d got=lat%0d/err%b/we%0d exp=lat1/err1/we0", i, lat, e, we_n);
      else n_pass++;
      n_checks++;
      if (ld_data !== ld_before || mem[1] !== m1 || mem[2] !== m2)
        $display("FAIL err_side_%0d got=%h/%h/%h exp=%h/%h/%h", i, ld_data, mem[1], mem[2], ld_before, m1, m2);
      else n_pass++;
    end
    drive_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, lat, e, we_n, ra);
    n_checks++;
    if (e !== 1'b0 || ld_data !== 32'hBEEFAB78)
      $display("FAIL err_recover got=err%b/%h exp=err0/BEEFAB78", e, ld_data);
    else n_pass++;
  endtask

  task automatic test_rst_in_wr();
    int dones = 0;
    @(negedge clk);
    is_store = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'd8; st_data = 32'hDEADBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (m_we !== 1'b1) $display("FAIL sw_wr_state got=%b exp=1", m_we); else n_pass++;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if (m_we !== 1'b0) $display("FAIL rst_gates_we got=%b exp=0", m_we); else n_pass++;
    @(posedge clk); #1;
    if (done === 1'b1) dones++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_wr_busy got=%b exp=0", busy); else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (mem[2] !== 32'h80FF0000 || dones !== 0)
      $display("FAIL rst_wr_mem got=%h dones=%0d exp=80FF0000 dones=0", mem[2], dones);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int dones = 0; int busy_seen = 0;
    @(negedge clk);
    is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'd8; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 3) start = 1'b0;
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 1 || busy_seen !== 2)
      $display("FAIL busy_ignore got=dones%0d/busy%0d exp=dones1/busy2", dones, busy_seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first = 0; int second = 0;
    @(negedge clk);
    is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'd4; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (first == 0) first = c;
        else if (second == 0) begin
          second = c;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (first !== 2 || second - first !== 3)
      $display("FAIL back_to_back got=first%0d/gap%0d exp=first2/gap3", first, second - first);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic e; int we_n; logic [31:0] ra;
    logic st, sx, mis; logic [1:0] sz; logic [31:0] a, d, exp_ld;
    int exp_lat;
    exp_ld = ld_data;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 63)); d = $urandom;
      mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      exp_lat = mis ? 1 : ((st && sz != 2'b10) ? 3 : 2);
      if (!mis && !st) exp_q.push_back(ref_load(ref_mem[a[5:2]], sz, sx, a[1:0]));
      if (!mis && st) ref_mem[a[5:2]] = ref_store(ref_mem[a[5:2]], sz, a[1:0], d);
      drive_req(st, sz, sx, a, d, lat, e, we_n, ra);
      if (exp_q.size() > 0) exp_ld = exp_q.pop_front();
      n_checks++;
      if (lat !== exp_lat || e !== mis || we_n !== ((!mis && st) ? 1 : 0))
        $display("FAIL rnd_%0d_ctl got=lat%0d/err%b/we%0d exp=lat%0d/err%b", i, lat, e, we_n, exp_lat, mis);
      else n_pass++;
      n_checks++;
      if (ld_data !== exp_ld || mem[a[5:2]] !== ref_mem[a[5:2]])
        $display("FAIL rnd_%0d_data got=%h/%h exp=%h/%h", i, ld_data, mem[a[5:2]], exp_ld, ref_mem[a[5:2]]);
      else n_pass++;
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_lw();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_rst_in_wr();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
